// File: rtl/phase_lock_if.sv
// phase_lock_if
// Bundles the measurement inputs and result outputs of one phase_lock_monitor.
//   enable_i     : measurement enable (master -> monitor)
//   ref_i, fb_i  : reference and ADPLL feedback square waves, asynchronous
//   phase_err_o  : signed offset in clock cycles, positive = fb lags ref
//   err_valid_o  : one-cycle pulse when phase_err_o is updated
//   locked_o     : lock indicator
//   slip_o       : one-cycle pulse on a cycle slip or measurement timeout
//   dbg_state_o  : current measurement FSM state, for observation only
// Handshake: there is no back-pressure. err_valid_o qualifies phase_err_o for
// exactly the one cycle it is high, and the consumer must take it then.
// locked_o and slip_o change only in a cycle where err_valid_o or slip_o is high.
interface phase_lock_if #(
    parameter int CNT_WIDTH = 8
);
    logic                 enable_i;
    logic                 ref_i;
    logic                 fb_i;
    logic [CNT_WIDTH-1:0] phase_err_o;
    logic                 err_valid_o;
    logic                 locked_o;
    logic                 slip_o;
    logic [1:0]           dbg_state_o;

    modport slave (
        input  enable_i, ref_i, fb_i,
        output phase_err_o, err_valid_o, locked_o, slip_o, dbg_state_o
    );

    modport master (
        output enable_i, ref_i, fb_i,
        input  phase_err_o, err_valid_o, locked_o, slip_o, dbg_state_o
    );
endinterface

// File: rtl/phase_lock_monitor.sv
// phase_lock_monitor
// Measures the signed offset, in fpga_clk_i cycles, between rising edges of a
// reference stream and an ADPLL feedback stream, and declares lock after a run
// of in-tolerance measurements.
//   fpga_clk_i : system clock
//   reset_n_i  : asynchronous active-low reset
//   bus        : phase_lock_if slave modport (enable, ref/fb inputs, results)
module phase_lock_monitor #(
    parameter int CNT_WIDTH     = 8,
    parameter int TOL           = 4,
    parameter int LOCK_COUNT    = 16,
    parameter int UNLOCK_MISSES = 2
) (
    input  logic         fpga_clk_i,
    input  logic         reset_n_i,
    phase_lock_if.slave  bus
);
    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W = $clog2(UNLOCK_MISSES + 1);

    localparam logic [1:0] ST_WAIT     = 2'd0;
    localparam logic [1:0] ST_REF_LEAD = 2'd1;
    localparam logic [1:0] ST_FB_LEAD  = 2'd2;

    localparam logic [CNT_WIDTH-2:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-2:0] TOL_V   = (CNT_WIDTH-1)'(TOL);
    localparam logic [GOOD_W-1:0]    LOCK_V  = GOOD_W'(LOCK_COUNT);
    localparam logic [MISS_W-1:0]    MISS_V  = MISS_W'(UNLOCK_MISSES);

    // Input conditioning: 2-flop synchronizer plus one delay flop per input.
    logic [1:0] ref_sync_q, fb_sync_q;
    logic       ref_dly_q, fb_dly_q;
    logic       ref_edge, fb_edge;

    always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ref_sync_q <= '0;
            fb_sync_q  <= '0;
            ref_dly_q  <= 1'b0;
            fb_dly_q   <= 1'b0;
        end else begin
            ref_sync_q <= {ref_sync_q[0], bus.ref_i};
            fb_sync_q  <= {fb_sync_q[0], bus.fb_i};
            ref_dly_q  <= ref_sync_q[1];
            fb_dly_q   <= fb_sync_q[1];
        end
    end

    assign ref_edge = ref_sync_q[1] & ~ref_dly_q;
    assign fb_edge  = fb_sync_q[1] & ~fb_dly_q;

    // Measurement FSM
    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-2:0] cnt_q, cnt_d;
    logic                 emit, emit_neg, slip_ev;
    logic [CNT_WIDTH-2:0] emit_mag;
    logic [CNT_WIDTH-2:0] close_mag;
    logic [CNT_WIDTH-1:0] mag_ext, err_val;

    // The closing count saturates rather than wrapping when the far edge lands
    // on the cycle the counter is already at its maximum.
    assign close_mag = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        emit     = 1'b0;
        emit_neg = 1'b0;
        emit_mag = '0;
        slip_ev  = 1'b0;
        if (!bus.enable_i) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (ref_edge && fb_edge) begin
                        emit = 1'b1;
                    end else if (ref_edge) begin
                        cnt_d   = '0;
                        state_d = ST_REF_LEAD;
                    end else if (fb_edge) begin
                        cnt_d   = '0;
                        state_d = ST_FB_LEAD;
                    end
                end
                ST_REF_LEAD: begin
                    if (fb_edge) begin
                        emit     = 1'b1;
                        emit_mag = close_mag;
                        cnt_d    = '0;
                        state_d  = ST_WAIT;
                    end else if (ref_edge) begin
                        slip_ev = 1'b1;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        emit     = 1'b1;
                        emit_mag = CNT_MAX;
                        slip_ev  = 1'b1;
                        cnt_d    = '0;
                        state_d  = ST_WAIT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_FB_LEAD: begin
                    emit_neg = 1'b1;
                    if (ref_edge) begin
                        emit     = 1'b1;
                        emit_mag = close_mag;
                        cnt_d    = '0;
                        state_d  = ST_WAIT;
                    end else if (fb_edge) begin
                        slip_ev = 1'b1;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        emit     = 1'b1;
                        emit_mag = CNT_MAX;
                        slip_ev  = 1'b1;
                        cnt_d    = '0;
                        state_d  = ST_WAIT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign mag_ext = {1'b0, emit_mag};
    assign err_val = emit_neg ? -mag_ext : mag_ext;

    // Lock qualification, evaluated on the measurement being emitted so that
    // locked_o moves in the same cycle as the err_valid_o that caused it.
    logic [GOOD_W-1:0] good_q, good_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic              locked_q, locked_d;

    always_comb begin
        good_d   = good_q;
        miss_d   = miss_q;
        locked_d = locked_q;
        if (slip_ev) begin
            good_d   = '0;
            miss_d   = '0;
            locked_d = 1'b0;
        end else if (emit) begin
            if (emit_mag <= TOL_V) begin
                miss_d = '0;
                if (good_q != LOCK_V) begin
                    good_d = good_q + 1'b1;
                end
                if (good_q == LOCK_V || good_q + 1'b1 == LOCK_V) begin
                    locked_d = 1'b1;
                end
            end else begin
                good_d = '0;
                if (miss_q + 1'b1 == MISS_V) begin
                    miss_d   = '0;
                    locked_d = 1'b0;
                end else begin
                    miss_d = miss_q + 1'b1;
                end
            end
        end
    end

    logic [CNT_WIDTH-1:0] err_q;
    logic                 valid_q, slip_q;

    always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= ST_WAIT;
            cnt_q    <= '0;
            good_q   <= '0;
            miss_q   <= '0;
            locked_q <= 1'b0;
            err_q    <= '0;
            valid_q  <= 1'b0;
            slip_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            good_q   <= good_d;
            miss_q   <= miss_d;
            locked_q <= locked_d;
            valid_q  <= emit;
            slip_q   <= slip_ev;
            if (emit) begin
                err_q <= err_val;
            end
        end
    end

    assign bus.phase_err_o = err_q;
    assign bus.err_valid_o = valid_q;
    assign bus.locked_o    = locked_q;
    assign bus.slip_o      = slip_q;
    assign bus.dbg_state_o = state_q;
endmodule

// File: tb/tb_phase_lock_monitor.sv
module tb_phase_lock_monitor;
  localparam int W = 8;
  localparam int TOL = 4;
  localparam int LOCK_COUNT = 16;
  localparam int UNLOCK_MISSES = 2;
  localparam int REC_W = W + 3;  // {slip, locked, err_valid, phase_err}

  logic clk;
  logic rst_n;
  int checks;
  int passes;

  logic [REC_W-1:0] exp_q[$];

  // bench reference model of lock qualification
  int m_good;
  int m_miss;
  logic m_locked;
  logic [W-1:0] m_last_err;

  phase_lock_if #(.CNT_WIDTH(W)) bus ();

  phase_lock_monitor #(
    .CNT_WIDTH(W), .TOL(TOL), .LOCK_COUNT(LOCK_COUNT), .UNLOCK_MISSES(UNLOCK_MISSES)
  ) dut (
    .fpga_clk_i(clk),
    .reset_n_i(rst_n),
    .bus(bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_good = 0;
    m_miss = 0;
    m_locked = 1'b0;
    m_last_err = '0;
  endtask

  // expected measurement with the given signed offset
  task automatic expect_meas(input int e);
    logic [W-1:0] ev;
    ev = W'(e);
    if (e <= TOL && e >= -TOL) begin
      m_miss = 0;
      if (m_good < LOCK_COUNT) m_good++;
      if (m_good == LOCK_COUNT) m_locked = 1'b1;
    end else begin
      m_good = 0;
      m_miss++;
      if (m_miss == UNLOCK_MISSES) begin
        m_miss = 0;
        m_locked = 1'b0;
      end
    end
    m_last_err = ev;
    exp_q.push_back({1'b0, m_locked, 1'b1, ev});
  endtask

  // expected slip pulse, optionally with a saturated measurement (timeout)
  task automatic expect_slip(input logic with_valid, input int e);
    m_good = 0;
    m_miss = 0;
    m_locked = 1'b0;
    if (with_valid) m_last_err = W'(e);
    exp_q.push_back({1'b1, 1'b0, with_valid, m_last_err});
  endtask

  // driver: one 64-cycle period, 8-cycle pulses on ref and fb, fb delayed by lag
  task automatic run_period(input int lag, input logic push);
    int a;
    int b;
    if (lag >= 0) begin a = 2; b = 2 + lag; end
    else begin a = 2 - lag; b = 2; end
    if (push) expect_meas(lag);
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      bus.ref_i = (c >= a && c < a + 8);
      bus.fb_i = (c >= b && c < b + 8);
    end
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      bus.ref_i = 1'b0;
      bus.fb_i = 1'b0;
    end
  endtask

  // scoreboard monitor: compare every presented output against the queue head
  always @(negedge clk) begin
    if (rst_n && (bus.err_valid_o || bus.slip_o)) begin
      logic [REC_W-1:0] act;
      act = {bus.slip_o, bus.locked_o, bus.err_valid_o, bus.phase_err_o};
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'(act), 32'hFFFF_FFFF);
      end else begin
        check("output_record", 32'(act), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    checks = 0;
    passes = 0;
    model_reset();
    rst_n = 1'b0;
    bus.enable_i = 1'b1;
    bus.ref_i = 1'b0;
    bus.fb_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_phase_err", 32'(bus.phase_err_o), 32'h0);
    check("reset_err_valid", 32'(bus.err_valid_o), 32'h0);
    check("reset_locked", 32'(bus.locked_o), 32'h0);
    check("reset_slip", 32'(bus.slip_o), 32'h0);
    check("reset_state", 32'(bus.dbg_state_o), 32'h0);
    rst_n = 1'b1;
    idle(4);

    // fb lags by 10: out of tolerance, never locks
    for (int i = 0; i < 4; i++) run_period(10, 1'b1);
    check("lag10_unlocked", 32'(bus.locked_o), 32'h0);
    // lag 3: locks on the 16th period
    for (int i = 0; i < 16; i++) run_period(3, 1'b1);
    check("lag3_locked", 32'(bus.locked_o), 32'h1);
    // one miss holds lock, two consecutive misses drop it
    run_period(20, 1'b1);
    check("single_miss_holds", 32'(bus.locked_o), 32'h1);
    run_period(3, 1'b1);
    run_period(20, 1'b1);
    run_period(20, 1'b1);
    check("double_miss_drops", 32'(bus.locked_o), 32'h0);
    // simultaneous edges: error 0, relock after 16
    for (int i = 0; i < 16; i++) run_period(0, 1'b1);
    check("simul_locked", 32'(bus.locked_o), 32'h1);
    // fb leads by 5 -> 0xFB, in tolerance
    for (int i = 0; i < 3; i++) run_period(-5, 1'b1);
    check("lead5_err", 32'(bus.phase_err_o), 32'h0FB);

    // enable low for 128 clocks: no outputs, lock held
    bus.enable_i = 1'b0;
    run_period(0, 1'b0);
    run_period(12, 1'b0);
    check("enable_low_lock_hold", 32'(bus.locked_o), 32'(m_locked));
    check("enable_low_err_hold", 32'(bus.phase_err_o), 32'h0FB);
    bus.enable_i = 1'b1;
    idle(4);

    // ref every 40 clocks, fb idle: slip on each ref after the first
    for (int k = 0; k < 4; k++) begin
      if (k > 0) expect_slip(1'b0, 0);
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        bus.ref_i = (c < 8);
        bus.fb_i = 1'b0;
      end
    end
    // then ref held low: timeout saturates at +127 with a slip
    expect_slip(1'b1, 127);
    idle(160);
    check("timeout_err", 32'(bus.phase_err_o), 32'h07F);
    check("timeout_unlocked", 32'(bus.locked_o), 32'h0);

    // relock, then reset in the middle of a REF_LEAD measurement
    for (int i = 0; i < 16; i++) run_period(1, 1'b1);
    check("relock", 32'(bus.locked_o), 32'h1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus.ref_i = (c >= 2 && c < 10);
      bus.fb_i = 1'b0;
    end
    check("mid_meas_state", 32'(bus.dbg_state_o), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_phase_err", 32'(bus.phase_err_o), 32'h0);
    check("async_rst_locked", 32'(bus.locked_o), 32'h0);
    check("async_rst_valid", 32'(bus.err_valid_o), 32'h0);
    check("async_rst_slip", 32'(bus.slip_o), 32'h0);
    check("async_rst_state", 32'(bus.dbg_state_o), 32'h0);
    model_reset();
    idle(3);
    rst_n = 1'b1;
    idle(4);
    run_period(7, 1'b1);
    check("post_reset_err", 32'(bus.phase_err_o), 32'h007);
    idle(8);

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
